// File: rtl/pea_fire_ctrl.sv
// Firing-permission controller for a PEA actor: checks FIFO tokens/space per command.
// Optional stall timeout is enabled by defining PEA_STALL_TIMEOUT_EN.
module pea_fire_ctrl #(
    parameter int buffer_size = 1024,
    parameter int deg_width   = 4,
    parameter int arg_width   = 5,
    parameter int stall_limit = 255,
    localparam int CW = (buffer_size <= 1) ? 1 : $clog2(buffer_size)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_valid,
    input  logic [2:0]           mode,
    input  logic [arg_width-1:0] b,
    input  logic [deg_width-1:0] N,
    input  logic [CW-1:0]        command_pop,
    input  logic [CW-1:0]        data_pop,
    input  logic [CW-1:0]        result_free_space,
    input  logic [CW-1:0]        status_free_space,
    input  logic                 fire_done,
    output logic                 enable,
    output logic                 busy,
    output logic                 err,
`ifdef PEA_STALL_TIMEOUT_EN
    output logic                 timeout,
`endif
    output logic [15:0]          stall_count
);

    localparam int M1   = (CW > deg_width + 1) ? CW : deg_width + 1;
    localparam int M2   = (M1 > arg_width) ? M1 : arg_width;
    localparam int CMPW = M2 + 1;

    localparam logic [2:0] M_GET = 3'd0;
    localparam logic [2:0] M_STP = 3'd1;
    localparam logic [2:0] M_EVP = 3'd2;
    localparam logic [2:0] M_EVB = 3'd3;
    localparam logic [2:0] M_RST = 3'd4;
    localparam logic [2:0] M_OUT = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        FIRE
    } state_e;

    state_e               state_q, state_d;
    logic [2:0]           mode_q, mode_d;
    logic [arg_width-1:0] b_q, b_d;
    logic [deg_width-1:0] n_q, n_d;
    logic [15:0]          stall_q, stall_d;
    logic                 enable_q, enable_d;
    logic                 err_q, err_d;
    logic                 tmo_q, tmo_d;

    logic [CMPW-1:0] cmd_x, dat_x, res_x, sta_x, b_x, n1_x, one_x;
    logic            fire_ok, illegal, rst_cmd;

    // Common width keeps N+1 from wrapping and makes every compare unsigned
    assign cmd_x = CMPW'(command_pop);
    assign dat_x = CMPW'(data_pop);
    assign res_x = CMPW'(result_free_space);
    assign sta_x = CMPW'(status_free_space);
    assign b_x   = CMPW'(b_q);
    assign one_x = CMPW'(1);
    assign n1_x  = CMPW'(n_q) + one_x;

    assign illegal = (mode_q > M_OUT);
    assign rst_cmd = mode_valid && (mode == M_RST);

    always_comb begin
        fire_ok = 1'b0;
        case (mode_q)
            M_GET:   fire_ok = (cmd_x >= one_x);
            M_STP:   fire_ok = (dat_x >= n1_x);
            M_EVP:   fire_ok = (dat_x >= one_x);
            M_EVB:   fire_ok = (dat_x >= b_x);
            M_RST:   fire_ok = 1'b1;
            M_OUT:   fire_ok = (res_x >= b_x) && (sta_x >= b_x);
            default: fire_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        b_d      = b_q;
        n_d      = n_q;
        stall_d  = stall_q;
        enable_d = 1'b0;
        err_d    = 1'b0;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_valid) begin
                    mode_d  = mode;
                    b_d     = b;
                    n_d     = N;
                    stall_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (rst_cmd) begin
                    mode_d   = M_RST;
                    state_d  = FIRE;
                    enable_d = 1'b1;
                end else if (illegal) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (fire_ok) begin
                    state_d  = FIRE;
                    enable_d = 1'b1;
`ifdef PEA_STALL_TIMEOUT_EN
                end else if (stall_q >= 16'(stall_limit)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
`endif
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            FIRE: begin
                enable_d = 1'b1;
                if (rst_cmd) begin
                    mode_d = M_RST;
                end else if (fire_done) begin
                    state_d  = IDLE;
                    enable_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            b_q      <= '0;
            n_q      <= '0;
            stall_q  <= '0;
            enable_q <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            b_q      <= b_d;
            n_q      <= n_d;
            stall_q  <= stall_d;
            enable_q <= enable_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign enable      = enable_q;
    assign busy        = (state_q != IDLE);
    assign err         = err_q;
    assign stall_count = stall_q;
`ifdef PEA_STALL_TIMEOUT_EN
    assign timeout     = tmo_q;
`else
    logic unused_tmo;
    assign unused_tmo = tmo_q;
`endif

endmodule

// File: tb/tb_pea_fire_ctrl.sv
// Bench for pea_fire_ctrl: vector table with scoreboard plus multi-cycle sequences.
module tb_pea_fire_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_valid;
    logic [2:0] mode;
    logic [4:0] b;
    logic [3:0] N;
    logic [9:0] command_pop, data_pop, result_free_space, status_free_space;
    logic       fire_done;
    logic       enable, busy, err;
    logic [15:0] stall_count;
`ifdef PEA_STALL_TIMEOUT_EN
    logic       timeout;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pea_fire_ctrl #(
        .buffer_size(1024),
        .deg_width(4),
        .arg_width(5),
        .stall_limit(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_valid(mode_valid),
        .mode(mode),
        .b(b),
        .N(N),
        .command_pop(command_pop),
        .data_pop(data_pop),
        .result_free_space(result_free_space),
        .status_free_space(status_free_space),
        .fire_done(fire_done),
        .enable(enable),
        .busy(busy),
        .err(err),
`ifdef PEA_STALL_TIMEOUT_EN
        .timeout(timeout),
`endif
        .stall_count(stall_count)
    );

    typedef struct {
        logic [2:0] mode;
        logic [4:0] b;
        logic [3:0] n;
        logic [9:0] cmd, dat, res, sta;
        logic       en;
        logic       er;
    } vec_t;

    typedef struct {
        logic en;
        logic er;
        logic bz;
        int   id;
    } exp_t;

    vec_t vt[16];
    exp_t sbq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [2:0] m, input logic [4:0] bb, input logic [3:0] nn);
        mode_valid = 1'b1;
        mode = m;
        b = bb;
        N = nn;
        tick();
        mode_valid = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   k;
        vt[0]  = '{3'd0, 5'd0,  4'd0,  10'd0, 10'd0,  10'd0,   10'd0,  1'b0, 1'b0};
        vt[1]  = '{3'd0, 5'd0,  4'd0,  10'd1, 10'd0,  10'd0,   10'd0,  1'b1, 1'b0};
        vt[2]  = '{3'd1, 5'd0,  4'd15, 10'd0, 10'd15, 10'd0,   10'd0,  1'b0, 1'b0};
        vt[3]  = '{3'd1, 5'd0,  4'd15, 10'd0, 10'd16, 10'd0,   10'd0,  1'b1, 1'b0};
        vt[4]  = '{3'd1, 5'd0,  4'd0,  10'd0, 10'd1,  10'd0,   10'd0,  1'b1, 1'b0};
        vt[5]  = '{3'd2, 5'd0,  4'd0,  10'd5, 10'd0,  10'd0,   10'd0,  1'b0, 1'b0};
        vt[6]  = '{3'd2, 5'd0,  4'd0,  10'd0, 10'd1,  10'd0,   10'd0,  1'b1, 1'b0};
        vt[7]  = '{3'd3, 5'd5,  4'd0,  10'd0, 10'd4,  10'd0,   10'd0,  1'b0, 1'b0};
        vt[8]  = '{3'd3, 5'd0,  4'd0,  10'd0, 10'd0,  10'd0,   10'd0,  1'b1, 1'b0};
        vt[9]  = '{3'd3, 5'd31, 4'd0,  10'd0, 10'd30, 10'd0,   10'd0,  1'b0, 1'b0};
        vt[10] = '{3'd4, 5'd0,  4'd0,  10'd0, 10'd0,  10'd0,   10'd0,  1'b1, 1'b0};
        vt[11] = '{3'd5, 5'd2,  4'd0,  10'd0, 10'd0,  10'd2,   10'd1,  1'b0, 1'b0};
        vt[12] = '{3'd5, 5'd2,  4'd0,  10'd0, 10'd0,  10'd2,   10'd2,  1'b1, 1'b0};
        vt[13] = '{3'd5, 5'd31, 4'd0,  10'd0, 10'd0,  10'd1023, 10'd31, 1'b1, 1'b0};
        vt[14] = '{3'd6, 5'd0,  4'd0,  10'd9, 10'd9,  10'd9,   10'd9,  1'b0, 1'b1};
        vt[15] = '{3'd7, 5'd0,  4'd0,  10'd9, 10'd9,  10'd9,   10'd9,  1'b0, 1'b1};

        rst = 1'b0;
        mode_valid = 1'b0;
        mode = '0;
        b = '0;
        N = '0;
        command_pop = '0;
        data_pop = '0;
        result_free_space = '0;
        status_free_space = '0;
        fire_done = 1'b0;

        #2;
        chk("rst_enable", enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_stall", stall_count, 0);
        mode_valid = 1'b1;
        tick();
        chk("rst_hold_busy", busy, 0);
        mode_valid = 1'b0;
        rst = 1'b1;
        tick();

        fire_done = 1'b1;
        tick();
        fire_done = 1'b0;
        chk("done_idle_busy", busy, 0);
        chk("done_idle_en", enable, 0);

        for (int i = 0; i < 16; i++) begin
            command_pop = vt[i].cmd;
            data_pop = vt[i].dat;
            result_free_space = vt[i].res;
            status_free_space = vt[i].sta;
            start(vt[i].mode, vt[i].b, vt[i].n);
            chk($sformatf("v%0d_check_busy", i), busy, 1);
            chk($sformatf("v%0d_check_en", i), enable, 0);
            sbq.push_back('{vt[i].en, vt[i].er, !vt[i].er, i});
            tick();
            e = sbq.pop_front();
            chk($sformatf("v%0d_en", e.id), enable, e.en);
            chk($sformatf("v%0d_err", e.id), err, e.er);
            chk($sformatf("v%0d_busy", e.id), busy, e.bz);
            if (!vt[i].er && !vt[i].en) begin
                mode_valid = 1'b1;
                mode = 3'd4;
                tick();
                mode_valid = 1'b0;
                chk($sformatf("v%0d_rstcmd_en", i), enable, 1);
            end
            if (!vt[i].er) begin
                fire_done = 1'b1;
                tick();
                fire_done = 1'b0;
                chk($sformatf("v%0d_done_en", i), enable, 0);
            end else begin
                tick();
            end
            chk($sformatf("v%0d_end_err", i), err, 0);
            chk($sformatf("v%0d_end_busy", i), busy, 0);
        end

        data_pop = 10'd4;
        start(3'd3, 5'd5, 4'd0);
        chk("evb_stall0", stall_count, 0);
        tick();
        fire_done = 1'b1;
        tick();
        fire_done = 1'b0;
        chk("evb_done_in_check", busy, 1);
        tick();
        chk("evb_stall3", stall_count, 3);
        chk("evb_no_en", enable, 0);
        data_pop = 10'd5;
        tick();
        chk("evb_fire", enable, 1);
        chk("evb_stall_hold", stall_count, 3);
        fire_done = 1'b1;
        tick();
        fire_done = 1'b0;
        chk("evb_off_en", enable, 0);
        chk("evb_off_busy", busy, 0);

        data_pop = 10'd1;
        start(3'd2, 5'd0, 4'd0);
        tick();
        chk("evp_fire", enable, 1);
        mode_valid = 1'b1;
        mode = 3'd1;
        tick();
        chk("fire_ignore_mv", dut.mode_q, 2);
        chk("fire_ignore_en", enable, 1);
        mode = 3'd4;
        fire_done = 1'b1;
        tick();
        mode_valid = 1'b0;
        fire_done = 1'b0;
        chk("rst_prio_en", enable, 1);
        chk("rst_prio_busy", busy, 1);
        chk("rst_relatch", dut.mode_q, 4);
        rst = 1'b0;
        #1;
        chk("async_en", enable, 0);
        chk("async_busy", busy, 0);
        chk("async_mode", dut.mode_q, 0);
        #2;
        rst = 1'b1;
        tick();

        command_pop = 10'd0;
        start(3'd0, 5'd0, 4'd0);
`ifdef PEA_STALL_TIMEOUT_EN
        k = 0;
        while (!timeout && k < 20) begin
            tick();
            k++;
        end
        chk("tmo_seen", timeout, 1);
        chk("tmo_cycles", k, 5);
        chk("tmo_stall", stall_count, 4);
        chk("tmo_err", err, 1);
        chk("tmo_busy", busy, 0);
        chk("tmo_en", enable, 0);
        tick();
        chk("tmo_pulse", timeout, 0);
        chk("tmo_err_pulse", err, 0);
`else
        k = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            k += int'(enable);
        end
        chk("wait_stall", stall_count, 8);
        chk("wait_busy", busy, 1);
        chk("wait_en", k, 0);
        chk("wait_err", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
